rect_draw_scheduler: RTL and testbench
======================================

Name: rect_draw_scheduler

Overview:
- Shares one rectangle drawer (rectDrawer) among N_REQ requesters, e.g. the signal bars, a status panel and a clear-screen request.
- Runs on the 50 MHz system clock; the drawer's done pulse is a handshake input, never a clock.
- Arbitrates round-robin, latches the winner's rectangle and colour, and drives the drawer and the VGA plot enable.
- Acknowledges the requester when its rectangle finishes, or aborts it on timeout.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- TIMEOUT_CYCLES, 2^20, cycles allowed per rectangle before abort
- TO_W, 21, width of the timeout counter (must hold TIMEOUT_CYCLES)

Ports:
- clk  in  1  system clock (CLOCK_50)
- resetn  in  1  asynchronous active-low reset
- req  in  N_REQ  per-requester draw request, level
- req_x  in  N_REQ*10  packed x origin, requester i at [i*10+:10]
- req_y  in  N_REQ*9  packed y origin
- req_w  in  N_REQ*10  packed width
- req_h  in  N_REQ*10  packed height
- req_colour  in  N_REQ*3  packed colour
- ack  out  N_REQ  one-cycle pulse: rectangle for requester i finished
- grant  out  N_REQ  one-hot, owner of the drawer (0 when idle)
- rd_enable  out  1  drawer enable; also VGA plot
- rd_x  out  10  latched x origin to drawer
- rd_y  out  9  latched y origin
- rd_w  out  10  latched width
- rd_h  out  10  latched height
- colour  out  3  latched colour to VGA adapter
- rd_done  in  1  drawer completion pulse, synchronous to clk
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  sticky; set on abort, cleared only by reset

Behaviour:
- Reset (async, resetn=0): state=IDLE; rr pointer=0; all outputs 0, including ack, grant, rd_* and timeout_err. Reset mid-draw drops rd_enable immediately; the pending draw is lost and no ack is issued.
- FSM states: IDLE, DRAW, GAP.
- IDLE: if any req bit is high at edge t, pick the winner with rr_arbiter, searching from index ptr upward and wrapping modulo N_REQ. At edge t:
  - latch the winner's x/y/w/h/colour into the rd_* and colour registers;
  - set grant to the winner one-hot;
  - go to DRAW. rd_enable is therefore high from cycle t+1.
- DRAW: rd_enable=1 and the latched values are held stable, even if the req inputs change.
  - If rd_done=1: pulse ack[winner] for exactly the next cycle, set ptr=(winner+1) mod N_REQ, go to GAP.
  - Otherwise, if the timeout counter reaches TIMEOUT_CYCLES-1: set timeout_err, advance ptr as above, go to GAP, no ack.
  - The timeout counter clears on entry to DRAW.
- GAP: exactly one cycle with rd_enable=0 and grant=0 so the drawer re-arms; ack is visible in this cycle. Then go to IDLE.
- Minimum turnaround: 2 idle cycles between consecutive rectangles.
- Request rules:
  - A requester holds req until it sees its ack.
  - req dropped mid-draw: the draw completes and ack is still pulsed.
  - req still high in the GAP cycle: the request is eligible again, but round-robin order applies.
- rd_done outside DRAW is ignored.
- rd_done and timeout in the same cycle: rd_done wins, giving ack and no error.
- Zero width or height is passed through unchanged; the scheduler does not validate geometry.
- Fairness: with all requests asserted continuously, each requester is served once per N_REQ grants.

Decomposition:
- Shared package/include (draw_defs.vh):
  - coordinate widths X_W=10, Y_W=9, DIM_W=10, COLOUR_W=3;
  - state encodings S_IDLE=2'd0, S_DRAW=2'd1, S_GAP=2'd2.
- One sub-module, rr_arbiter: combinational.
  - Inputs: req[N_REQ-1:0], ptr.
  - Outputs: one-hot gnt, binary index, any.
  - The pointer register stays in rect_draw_scheduler.

Test Plan:
- Single request: req=4'b0001, x=195, y=95, w=75, h=10, colour=3'b010 -> grant=0001 and rd_enable one cycle later; rd_x=195, rd_y=95; rd_done after 750 cycles -> ack[0] one-cycle pulse, then GAP, then IDLE, busy=0.
- All four req high, rd_done returned 5 cycles into each draw -> grant sequence 0001, 0010, 0100, 1000, 0001 with ptr wrapping.
- Input change mid-draw: req_x[0] changed from 195 to 370 during DRAW -> rd_x stays 195 until the next grant.
- Timeout: TIMEOUT_CYCLES=16, rd_done never asserted -> rd_enable drops after 16 DRAW cycles, timeout_err=1, no ack, next requester granted.
- Reset mid-draw: resetn low during DRAW -> rd_enable, grant and busy go 0 asynchronously; after release, ptr=0 and a pending req[2] is granted.
- Simultaneous rd_done and timeout on the final count -> ack pulses, timeout_err stays 0.

Source files
------------

// File: rtl/rect_draw_scheduler_pkg.sv
// rect_draw_scheduler_pkg: geometry widths and FSM states shared by the rectangle scheduler
package rect_draw_scheduler_pkg;
  localparam int X_W      = 10;
  localparam int Y_W      = 9;
  localparam int DIM_W    = 10;
  localparam int COLOUR_W = 3;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRAW = 2'd1, S_GAP = 2'd2} state_t;
endpackage

// File: rtl/rect_draw_scheduler_rr_arbiter.sv
// rect_draw_scheduler_rr_arbiter: combinational round-robin pick, searching upward from ptr with wrap
module rect_draw_scheduler_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             any
);
  always_comb begin
    idx = '0;
    any = 1'b0;
    // scan farthest offset first so the nearest hit from ptr is the last one written
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N_REQ]) begin
        idx = IW'((int'(ptr) + k) % N_REQ);
        any = 1'b1;
      end
    gnt = any ? N_REQ'(1) << idx : '0;
  end
endmodule

// File: rtl/rect_draw_scheduler.sv
// rect_draw_scheduler: shares one rectangle drawer among N_REQ requesters with round-robin and timeout abort
module rect_draw_scheduler
  import rect_draw_scheduler_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 2**20,
  parameter int TO_W           = 21
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*X_W-1:0]    req_x,
  input  logic [N_REQ*Y_W-1:0]    req_y,
  input  logic [N_REQ*DIM_W-1:0]  req_w,
  input  logic [N_REQ*DIM_W-1:0]  req_h,
  input  logic [N_REQ*COLOUR_W-1:0] req_colour,
  output logic [N_REQ-1:0]        ack,
  output logic [N_REQ-1:0]        grant,
  output logic                    rd_enable,
  output logic [X_W-1:0]          rd_x,
  output logic [Y_W-1:0]          rd_y,
  output logic [DIM_W-1:0]        rd_w,
  output logic [DIM_W-1:0]        rd_h,
  output logic [COLOUR_W-1:0]     colour,
  input  logic                    rd_done,
  output logic                    busy,
  output logic                    timeout_err
);
  localparam int IW = $clog2(N_REQ);
  state_t state, state_n;
  logic [IW-1:0] ptr, win, idx;
  logic [N_REQ-1:0] gnt;
  logic any, to_hit;
  logic [TO_W-1:0] cnt;
  rect_draw_scheduler_rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
    .req(req), .ptr(ptr), .gnt(gnt), .idx(idx), .any(any)
  );
  assign to_hit    = cnt == TO_W'(TIMEOUT_CYCLES - 1);
  assign rd_enable = state == S_DRAW;
  assign busy      = state != S_IDLE;
  always_comb begin
    state_n = state == S_IDLE ? (any ? S_DRAW : S_IDLE) :
              state == S_DRAW ? ((rd_done || to_hit) ? S_GAP : S_DRAW) : S_IDLE;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= S_IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      ptr         <= '0;
      win         <= '0;
      cnt         <= '0;
      ack         <= '0;
      grant       <= '0;
      rd_x        <= '0;
      rd_y        <= '0;
      rd_w        <= '0;
      rd_h        <= '0;
      colour      <= '0;
      timeout_err <= 1'b0;
    end else begin
      ack <= '0;
      cnt <= state == S_DRAW ? cnt + 1'b1 : '0;
      if (state == S_IDLE && any) begin
        rd_x   <= req_x[idx*X_W +: X_W];
        rd_y   <= req_y[idx*Y_W +: Y_W];
        rd_w   <= req_w[idx*DIM_W +: DIM_W];
        rd_h   <= req_h[idx*DIM_W +: DIM_W];
        colour <= req_colour[idx*COLOUR_W +: COLOUR_W];
        grant  <= gnt;
        win    <= idx;
      end
      // rd_done takes priority over a coincident timeout
      if (state == S_DRAW && (rd_done || to_hit)) begin
        grant <= '0;
        ptr   <= win == IW'(N_REQ - 1) ? '0 : win + 1'b1;
        if (rd_done) ack <= grant;
        else timeout_err <= 1'b1;
      end
    end
endmodule

// File: tb/tb_rect_draw_scheduler.sv
// tb_rect_draw_scheduler: randomized transaction-level check of the rectangle scheduler
module tb_rect_draw_scheduler;
  localparam int N  = 4;
  localparam int TO = 16;
  logic clk = 1'b0, resetn = 1'b0;
  logic [N-1:0] req = '0;
  logic [N*10-1:0] req_x = '0, req_w = '0, req_h = '0;
  logic [N*9-1:0] req_y = '0;
  logic [N*3-1:0] req_colour = '0;
  logic rd_done = 1'b0;
  logic [N-1:0] ack, grant;
  logic rd_enable, busy, timeout_err;
  logic [9:0] rd_x, rd_w, rd_h;
  logic [8:0] rd_y;
  logic [2:0] colour;
  int n_chk = 0, n_err = 0;
  int ptr_m = 0;
  logic err_m = 1'b0;

  rect_draw_scheduler #(.N_REQ(N), .TIMEOUT_CYCLES(TO), .TO_W(5)) dut (
    .clk(clk), .resetn(resetn), .req(req), .req_x(req_x), .req_y(req_y),
    .req_w(req_w), .req_h(req_h), .req_colour(req_colour), .ack(ack),
    .grant(grant), .rd_enable(rd_enable), .rd_x(rd_x), .rd_y(rd_y),
    .rd_w(rd_w), .rd_h(rd_h), .colour(colour), .rd_done(rd_done),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_fields();
    for (int i = 0; i < N; i++) begin
      req_x[i*10 +: 10]     = 10'($urandom);
      req_y[i*9 +: 9]       = 9'($urandom);
      req_w[i*10 +: 10]     = 10'($urandom);
      req_h[i*10 +: 10]     = 10'($urandom);
      req_colour[i*3 +: 3]  = 3'($urandom);
    end
  endtask

  // one request round from an IDLE negedge; d = DRAW cycle carrying rd_done (>= TO means never)
  task automatic draw(input logic [N-1:0] r, input int d);
    int w, e;
    logic done;
    logic [9:0] ex, ew, eh;
    logic [8:0] ey;
    logic [2:0] ec;
    req = r;
    rd_done = 1'($urandom);
    if (r == '0) begin
      @(negedge clk);
      check("idle_busy", 32'(busy), 0);
      check("idle_grant", 32'(grant), 0);
      rd_done = 1'b0;
      return;
    end
    w = -1;
    for (int k = 0; k < N; k++)
      if (w < 0 && r[(ptr_m + k) % N]) w = (ptr_m + k) % N;
    ex = req_x[w*10 +: 10];
    ey = req_y[w*9 +: 9];
    ew = req_w[w*10 +: 10];
    eh = req_h[w*10 +: 10];
    ec = req_colour[w*3 +: 3];
    done = d < TO;
    e = done ? d : TO - 1;
    for (int k = 0; k <= e; k++) begin
      @(negedge clk);
      check("draw_en", 32'(rd_enable), 1);
      check("draw_grant", 32'(grant), 32'(1 << w));
      check("draw_x", 32'(rd_x), 32'(ex));
      if (k == 0) begin
        check("draw_y", 32'(rd_y), 32'(ey));
        check("draw_w", 32'(rd_w), 32'(ew));
        check("draw_h", 32'(rd_h), 32'(eh));
        check("draw_colour", 32'(colour), 32'(ec));
        check("draw_busy", 32'(busy), 1);
      end
      rd_done = k == d;
      req = N'($urandom);
      set_fields();
    end
    @(negedge clk);
    ptr_m = (w + 1) % N;
    if (!done) err_m = 1'b1;
    check("gap_en", 32'(rd_enable), 0);
    check("gap_grant", 32'(grant), 0);
    check("gap_ack", 32'(ack), done ? 32'(1 << w) : 0);
    check("gap_err", 32'(timeout_err), 32'(err_m));
    check("gap_busy", 32'(busy), 1);
    rd_done = 1'($urandom);
    @(negedge clk);
    check("idle_en", 32'(rd_enable), 0);
    check("idle_busy", 32'(busy), 0);
    check("idle_ack", 32'(ack), 0);
    check("idle_hold_x", 32'(rd_x), 32'(ex));
    rd_done = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_en", 32'(rd_enable), 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_err", 32'(timeout_err), 0);
    check("rst_x", 32'(rd_x), 0);
    resetn = 1'b1;
    @(negedge clk);
    set_fields();
    req_x[0 +: 10] = 10'd195;
    req_y[0 +: 9]  = 9'd95;
    req_w[0 +: 10] = 10'd75;
    req_h[0 +: 10] = 10'd10;
    req_colour[0 +: 3] = 3'b010;
    draw(4'b0001, 10);
    repeat (5) begin
      set_fields();
      draw(4'b1111, 5);
    end
    set_fields();
    draw(4'b0100, 15);
    set_fields();
    draw(4'b0010, 100);
    repeat (300) begin
      set_fields();
      draw(N'($urandom), $urandom_range(0, 20));
    end
    set_fields();
    req = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("arst_en", 32'(rd_enable), 0);
    check("arst_grant", 32'(grant), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_err", 32'(timeout_err), 0);
    @(negedge clk);
    resetn = 1'b1;
    ptr_m = 0;
    err_m = 1'b0;
    set_fields();
    draw(4'b0100, 3);
    set_fields();
    draw(4'b1111, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
